// File: rtl/mux8_sel_seq.sv
// Select sequencer feeding an 8:1 mux: holds a loaded word on d_out and steps sel through all
// eight indices at a programmable slot length. Optional abort input: define MUX8_SEQ_ABORT_EN.
module mux8_sel_seq #(
  parameter int DIV_W     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef MUX8_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [7:0]       load_data,
  input  logic [DIV_W-1:0] div,
  output logic [7:0]       d_out,
  output logic [2:0]       sel,
  output logic             bit_strobe,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam logic [2:0] SEL_FIRST = MSB_FIRST ? 3'd7 : 3'd0;

  state_t             state_reg, state_next;
  logic [7:0]         d_out_reg, d_out_next;
  logic [DIV_W-1:0]   div_q_reg, div_q_next;
  logic [DIV_W-1:0]   slot_cnt_reg, slot_cnt_next;
  logic [2:0]         sel_reg, sel_next;
  logic [2:0]         bit_cnt_reg, bit_cnt_next;
  logic               done_reg, done_next;
  logic               busy_reg, busy_next;
  logic               abort_req;
  logic               slot_end;

`ifdef MUX8_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign slot_end   = (state_reg == ST_SHIFT) && (slot_cnt_reg == '0);
  // The strobe still fires on a slot end that coincides with an abort.
  assign bit_strobe = slot_end;
  assign load_ready = rst_n && (state_reg == ST_IDLE);

  assign d_out = d_out_reg;
  assign sel   = sel_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;

  always_comb begin
    state_next    = state_reg;
    d_out_next    = d_out_reg;
    div_q_next    = div_q_reg;
    slot_cnt_next = slot_cnt_reg;
    sel_next      = sel_reg;
    bit_cnt_next  = bit_cnt_reg;
    done_next     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (load_valid) begin
          state_next    = ST_SHIFT;
          d_out_next    = load_data;
          div_q_next    = div;
          sel_next      = SEL_FIRST;
          bit_cnt_next  = 3'd0;
          slot_cnt_next = div;
        end
      end
      ST_SHIFT: begin
        if (abort_req) begin
          state_next = ST_DONE;
          done_next  = 1'b1;
        end else if (slot_end) begin
          if (bit_cnt_reg == 3'd7) begin
            // sel stays on the final index through DONE and IDLE.
            state_next = ST_DONE;
            done_next  = 1'b1;
          end else begin
            bit_cnt_next  = bit_cnt_reg + 3'd1;
            sel_next      = MSB_FIRST ? (sel_reg - 3'd1) : (sel_reg + 3'd1);
            slot_cnt_next = div_q_reg;
          end
        end else begin
          slot_cnt_next = slot_cnt_reg - 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      d_out_reg    <= '0;
      div_q_reg    <= '0;
      slot_cnt_reg <= '0;
      sel_reg      <= '0;
      bit_cnt_reg  <= '0;
      done_reg     <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      d_out_reg    <= d_out_next;
      div_q_reg    <= div_q_next;
      slot_cnt_reg <= slot_cnt_next;
      sel_reg      <= sel_next;
      bit_cnt_reg  <= bit_cnt_next;
      done_reg     <= done_next;
      busy_reg     <= busy_next;
    end
  end

endmodule

// File: tb/tb_mux8_sel_seq.sv
// Directed bench for mux8_sel_seq: LSB-first instance u_dut0 and MSB-first instance u_dut1
// share clock and reset; abort steps run only when MUX8_SEQ_ABORT_EN is defined.
module tb_mux8_sel_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lv0, lv1;
  logic [7:0] ld0, ld1, dv0, dv1;
  logic       lr0, lr1, st0, st1, b0, b1, dn0, dn1;
  logic [7:0] d0, d1;
  logic [2:0] s0, s1;
`ifdef MUX8_SEQ_ABORT_EN
  logic       ab0, ab1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Hand-derived mux y sequences in slot order (leftmost bit = first slot).
  logic [0:7] y_a5 = 8'b1010_0101;
  logic [0:7] y_81 = 8'b1000_0001;

  always #5 clk = ~clk;

  mux8_sel_seq #(.DIV_W(8), .MSB_FIRST(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
`ifdef MUX8_SEQ_ABORT_EN
    .abort(ab0),
`endif
    .load_valid(lv0), .load_ready(lr0), .load_data(ld0), .div(dv0),
    .d_out(d0), .sel(s0), .bit_strobe(st0), .busy(b0), .done(dn0)
  );

  mux8_sel_seq #(.DIV_W(8), .MSB_FIRST(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef MUX8_SEQ_ABORT_EN
    .abort(ab1),
`endif
    .load_valid(lv1), .load_ready(lr1), .load_data(ld1), .div(dv1),
    .d_out(d1), .sel(s1), .bit_strobe(st1), .busy(b1), .done(dn1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    int nstb;
    int nsel0;

    rst_n = 1'b0;
    lv0 = 1'b0; lv1 = 1'b0;
    ld0 = 8'h00; ld1 = 8'h00;
    dv0 = 8'h00; dv1 = 8'h00;
`ifdef MUX8_SEQ_ABORT_EN
    ab0 = 1'b0; ab1 = 1'b0;
`endif
    repeat (3) tick;

    // Reset state
    chk("rst_sel", 32'(s0), 32'd0);
    chk("rst_dout", 32'(d0), 32'h00);
    chk("rst_busy", 32'(b0), 32'd0);
    chk("rst_done", 32'(dn0), 32'd0);
    chk("rst_ready_held", 32'(lr0), 32'd0);
    chk("rst_ready_held_m", 32'(lr1), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready_release", 32'(lr0), 32'd1);
    $display("reset: sel=%0d d_out=%h ready=%0d", s0, d0, lr0);

    // A5, div=0: one cycle per bit, strobe every cycle
    ld0 = 8'hA5; dv0 = 8'd0; lv0 = 1'b1;
    tick;
    lv0 = 1'b0;
    chk("t1_dout", 32'(d0), 32'hA5);
    for (int i = 0; i < 8; i++) begin
      chk("t1_sel", 32'(s0), 32'(i));
      chk("t1_y", 32'(d0[s0]), 32'(y_a5[i]));
      chk("t1_strobe", 32'(st0), 32'd1);
      chk("t1_busy", 32'(b0), 32'd1);
      chk("t1_ready_low", 32'(lr0), 32'd0);
      tick;
    end
    chk("t1_done", 32'(dn0), 32'd1);
    chk("t1_done_ready", 32'(lr0), 32'd0);
    chk("t1_done_strobe", 32'(st0), 32'd0);
    chk("t1_done_sel", 32'(s0), 32'd7);
    tick;
    chk("t1_idle_done", 32'(dn0), 32'd0);
    chk("t1_idle_ready", 32'(lr0), 32'd1);
    chk("t1_idle_busy", 32'(b0), 32'd0);
    chk("t1_idle_sel", 32'(s0), 32'd7);
    $display("frame A5 div=0 complete: sel=%0d", s0);

    // 3C, div=3: each index held 4 cycles, strobe on the 4th
    ld0 = 8'h3C; dv0 = 8'd3; lv0 = 1'b1;
    tick;
    lv0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) begin
        chk("t2_sel", 32'(s0), 32'(i));
        chk("t2_strobe", 32'(st0), (k == 3) ? 32'd1 : 32'd0);
        chk("t2_done_early", 32'(dn0), 32'd0);
        tick;
      end
    end
    chk("t2_done", 32'(dn0), 32'd1);
    tick;
    chk("t2_idle_ready", 32'(lr0), 32'd1);
    $display("frame 3C div=3 complete");

    // MSB-first instance: 81, div=1
    ld1 = 8'h81; dv1 = 8'd1; lv1 = 1'b1;
    tick;
    lv1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 2; k++) begin
        chk("t3_sel", 32'(s1), 32'(7 - i));
        chk("t3_y", 32'(d1[s1]), 32'(y_81[i]));
        chk("t3_strobe", 32'(st1), (k == 1) ? 32'd1 : 32'd0);
        tick;
      end
    end
    chk("t3_done", 32'(dn1), 32'd1);
    chk("t3_done_sel", 32'(s1), 32'd0);
    tick;
    chk("t3_idle_ready", 32'(lr1), 32'd1);
    chk("t3_idle_sel", 32'(s1), 32'd0);
    $display("frame 81 div=1 msb-first complete");

    // Back-to-back with load_valid held; mid-frame input changes ignored
    ld0 = 8'h11; dv0 = 8'd0; lv0 = 1'b1;
    tick;
    ld0 = 8'h22; dv0 = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      chk("t4_dout_hold", 32'(d0), 32'h11);
      chk("t4_sel", 32'(s0), 32'(i));
      tick;
    end
    chk("t4_done", 32'(dn0), 32'd1);
    chk("t4_done_ready", 32'(lr0), 32'd0);
    chk("t4_done_dout", 32'(d0), 32'h11);
    dv0 = 8'd0;
    tick;
    chk("t4_idle_ready", 32'(lr0), 32'd1);
    chk("t4_idle_done", 32'(dn0), 32'd0);
    tick;
    lv0 = 1'b0;
    chk("t4_second_dout", 32'(d0), 32'h22);
    chk("t4_second_sel", 32'(s0), 32'd0);
    chk("t4_second_busy", 32'(b0), 32'd1);
    repeat (8) tick;
    chk("t4_second_done", 32'(dn0), 32'd1);
    tick;
    $display("back-to-back 11/22 complete");

    // div=all-ones: 256 cycles per bit, 2048 SHIFT cycles
    ld0 = 8'h01; dv0 = 8'hFF; lv0 = 1'b1;
    tick;
    lv0 = 1'b0;
    cyc = 0; nstb = 0; nsel0 = 0;
    while (!dn0 && cyc < 3000) begin
      if (st0) nstb++;
      if (s0 == 3'd0) nsel0++;
      cyc++;
      tick;
    end
    chk("t5_shift_cycles", 32'(cyc), 32'd2048);
    chk("t5_strobes", 32'(nstb), 32'd8);
    chk("t5_slot0_len", 32'(nsel0), 32'd256);
    tick;
    $display("div=FF frame: %0d cycles, %0d strobes", cyc, nstb);

    // Reset mid-frame at sel=4, div=2
    ld0 = 8'hF0; dv0 = 8'd2; lv0 = 1'b1;
    tick;
    lv0 = 1'b0;
    repeat (12) tick;
    chk("t6_pre_sel", 32'(s0), 32'd4);
    rst_n = 1'b0;
    tick;
    chk("t6_rst_sel", 32'(s0), 32'd0);
    chk("t6_rst_dout", 32'(d0), 32'h00);
    chk("t6_rst_busy", 32'(b0), 32'd0);
    chk("t6_rst_done", 32'(dn0), 32'd0);
    chk("t6_rst_ready", 32'(lr0), 32'd0);
    tick;
    chk("t6_rst_done2", 32'(dn0), 32'd0);
    chk("t6_rst_ready2", 32'(lr0), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("t6_release_ready", 32'(lr0), 32'd1);
    tick;
    chk("t6_release_done", 32'(dn0), 32'd0);
    $display("mid-frame reset complete");

`ifdef MUX8_SEQ_ABORT_EN
    // Abort at sel=2 with div=1
    ld0 = 8'h55; dv0 = 8'd1; lv0 = 1'b1;
    tick;
    lv0 = 1'b0;
    nstb = 0;
    repeat (4) begin
      if (st0) nstb++;
      tick;
    end
    chk("t7_sel", 32'(s0), 32'd2);
    chk("t7_abort_strobe", 32'(st0), 32'd0);
    ab0 = 1'b1;
    tick;
    ab0 = 1'b0;
    chk("t7_done", 32'(dn0), 32'd1);
    chk("t7_strobes", 32'(nstb), 32'd2);
    chk("t7_done_strobe", 32'(st0), 32'd0);
    tick;
    chk("t7_idle_strobe", 32'(st0), 32'd0);
    chk("t7_idle_ready", 32'(lr0), 32'd1);
    chk("t7_idle_done", 32'(dn0), 32'd0);
    $display("abort at sel=2 complete: %0d strobes", nstb);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux8_sel_seq.md
Name: mux8_sel_seq

Overview:
Select sequencer that sits directly upstream of the 8:1 mux stage. It accepts an 8-bit word over a valid/ready handshake and holds it on d_out, which drives the mux d[7:0] input. It then steps sel, which drives the mux c[2:0] input, through all 8 indices at a programmable bit rate, so that the mux y output becomes a serial bitstream. It flags each stable bit slot with bit_strobe for the downstream sampler.

Parameters:
DIV_W, 8, width of the bit-slot divider; a slot lasts div+1 clocks.
MSB_FIRST, 0, 0 steps sel 0→7; 1 steps sel 7→0.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  synchronous reset, active-low.
load_valid  input  1  producer offers load_data.
load_ready  output  1  block can accept a word; high only in IDLE.
load_data  input  8  word to serialise.
div  input  DIV_W  slot length minus 1; sampled at load.
d_out  output  8  held word, driven to mux d[7:0].
sel  output  3  current index, driven to mux c[2:0].
bit_strobe  output  1  one-cycle pulse on the last clock of each slot.
busy  output  1  high in SHIFT and DONE.
done  output  1  one-cycle pulse after the 8th slot.

Behaviour:
- States:
  - IDLE: load_ready=1. On load_valid&&load_ready: capture load_data→d_out, div→div_q, sel←(MSB_FIRST?7:0), bit_cnt←0, slot_cnt←div. Next state is SHIFT.
  - SHIFT: slot_cnt decrements each clock. When slot_cnt==0: bit_strobe=1 in that cycle. Then, if bit_cnt==7, go to DONE. Otherwise bit_cnt++, sel±1, slot_cnt←div_q.
  - DONE: done=1 for exactly one cycle, load_ready=0. Next state is IDLE.
- Outputs:
  - All outputs are registered, except load_ready and bit_strobe, which are decoded from the state and counters.
  - load_ready is forced to 0 while rst_n=0.
- Reset (rst_n low at a clk edge): state=IDLE, d_out=0, sel=0, bit_cnt=0, slot_cnt=0, done=0, busy=0. Reset mid-frame aborts the frame immediately; no done pulse; d_out is cleared.
- Timing:
  - Latency: handshake at edge N; sel shows the first index from cycle N+1.
  - Each sel value is held for div_q+1 cycles.
  - Frame length from handshake to the done pulse is 8*(div_q+1) cycles, plus 1 cycle in DONE.
- Stability: d_out and div_q are stable for the whole frame. load_data and div changes outside IDLE are ignored.
- Boundaries:
  - div=0 gives one cycle per bit, and bit_strobe is high in every SHIFT cycle.
  - div=all-ones gives 2^DIV_W cycles per bit.
  - sel never wraps. The frame ends at index 7 (MSB_FIRST=0) or 0 (MSB_FIRST=1), and sel holds that value through DONE and IDLE until the next load.
- Back-to-back: a new word is accepted at the earliest one cycle after done, i.e. in the first IDLE cycle. A load_valid held high through DONE is accepted then.
- The producer must hold load_valid and load_data until it sees load_ready high; dropping load_valid earlier is legal and loads nothing.

Optional Feature:
- Macro: MUX8_SEQ_ABORT_EN.
- When defined, an input port abort (1 bit) is added.
  - abort=1 in SHIFT: at the next edge, go to DONE without a bit_strobe in that cycle; done still pulses once.
  - abort is ignored in IDLE and DONE.
  - abort=1 in the same cycle as a slot-end strobe: the strobe still fires; the frame then goes to DONE.
- When not defined, the port is absent and a frame always runs all 8 slots.

Test Plan:
- Reset, then load 8'hA5 with div=0, MSB_FIRST=0 → sel reads 0,1,…,7 on consecutive cycles; mux y reads 1,0,1,0,0,1,0,1; 8 strobes; done 8 cycles after the first sel; load_ready returns 1 cycle later.
- Load 8'h3C with div=3 → each sel value is held for 4 cycles; strobe on the 4th; done 32 cycles after the first sel.
- MSB_FIRST=1, load 8'h81, div=1 → sel 7,6,…,0, each held 2 cycles; y reads 1,0,0,0,0,0,0,1.
- load_valid held high with words 8'h11 then 8'h22 → second handshake exactly 1 cycle after the done pulse; load_data changes mid-frame do not alter d_out.
- Drop rst_n at sel=4 during div=2 → next cycle: IDLE, sel=0, d_out=0, no done pulse; load_ready=0 while reset is held, 1 after release.
- With MUX8_SEQ_ABORT_EN, pulse abort at sel=2 → done pulses the next cycle; 2 strobes in total, none after the abort.
